icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and memCtrl.
//  Hits return the instruction combinationally in the request cycle.
//  Misses issue a 4-byte fetch on memCtrl's icache port, fill the line, then serve the retried lookup.
//  A flush from the commit stage aborts an in-flight miss.
// PARAMETERS
//  INDEX_W   8    index bits; 2**INDEX_W lines, index = if_pc[INDEX_W+1:2]
//  TAG_W     30-INDEX_W  tag = if_pc[31:INDEX_W+2]; bits [1:0] are ignored (aligned fetch)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  rdy         in   1   global ready; 0 = freeze all state
//  flush       in   1   mispredict/clear; aborts outstanding miss
//  if_valid    in   1   fetch request
//  if_pc       in   32  fetch address, held stable by IF until if_ready or flush
//  if_ready    out  1   instruction valid this cycle
//  if_inst     out  32  instruction
//  mem_valid   out  1   to memCtrl icache_valid
//  mem_addr    out  32  to memCtrl icache_ain
//  mem_enable  in   1   from memCtrl icache_enable (1-cycle pulse)
//  mem_data    in   32  from memCtrl icache_dout (little-endian word)
// BEHAVIOUR
//  - Storage: valid[2**INDEX_W], tag[]/data[] arrays. Only valid[] and control state are reset.
//  - Reset (rst_n=0, async): all valid=0, state=IDLE, miss_pc=0, mem_addr=0.
//    Combinational outputs then read: if_ready=0, mem_valid=0, if_inst=data of indexed line (don't care).
//  - hit = valid[idx] && tag[idx]==if_pc tag.
//  - if_ready = rdy && state==IDLE && if_valid && hit && !flush.
//    if_inst = data[idx]; zero-cycle latency on hit.
//  - FSM states: IDLE, MISS.
//    - IDLE -> MISS when rdy && if_valid && !hit && !flush.
//      Latch miss_pc = {if_pc[31:2],2'b00}; mem_addr <= same.
//    - MISS: mem_valid = (state==MISS) && !mem_enable && !flush. Combinational.
//      It must be low in the mem_enable cycle so memCtrl's IDLE does not restart the fetch.
//    - MISS, mem_enable=1: write data/tag at miss_pc index, set valid, state <= IDLE.
//      The retried lookup hits the next cycle.
//      Miss latency = 1 (detect) + memCtrl fetch + 1 (retry hit).
//    - MISS, flush=1, mem_enable=0: state <= IDLE, no fill. mem_valid drops the same cycle, so memCtrl aborts.
//    - MISS, flush=1 and mem_enable=1 together: line IS filled (data correct for miss_pc), state <= IDLE.
//  - flush in IDLE: no state change; if_ready forced 0 that cycle.
//  - rdy=0: no register updates. mem_valid and if_ready are gated to 0 while rdy=0.
//    memCtrl drops its enable in that case.
//  - if_pc changing during MISS without flush is illegal. Fill still targets the latched miss_pc.
//  - Index aliasing: a fill overwrites the existing line unconditionally; there is no replacement choice.
//  - Fill writes and hit reads of the same index in one cycle cannot occur (if_ready requires IDLE).
// CONFIGURATION
//  ICACHE_PERF_EN defined:
//    - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//    - hit_cnt increments on each if_ready. miss_cnt increments on each IDLE->MISS transition.
//    - Both reset to 0 asynchronously, both wrap at 2**32, both frozen when rdy=0.
//  ICACHE_PERF_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1. Cold miss:
//     - Stimulus: reset, then if_valid=1, if_pc=0x0000_1004.
//     - Expected: if_ready=0; next cycle mem_valid=1, mem_addr=0x1004.
//     - Memory model answers mem_data=0x00A00093 with mem_enable.
//     - Expected: mem_valid=0 that cycle; next cycle if_ready=1, if_inst=0x00A00093.
//  2. Hit:
//     - Stimulus: re-request pc 0x1004.
//     - Expected: if_ready=1 the same cycle, mem_valid stays 0.
//  3. Conflict:
//     - Stimulus: with INDEX_W=8, fetch 0x1004 then 0x1404 (same index, different tag).
//     - Expected: second fetch misses; a third fetch to 0x1004 misses again.
//  4. Flush abort:
//     - Stimulus: miss on 0x2000, flush=1 two cycles into the fetch.
//     - Expected: mem_valid=0 that cycle, state IDLE, valid[0x00] unchanged; a later 0x2000 fetch misses.
//  5. Flush coincident with mem_enable:
//     - Expected: line filled; a later 0x2000 request hits with no mem_valid.
//  6. rdy low and reset mid-operation:
//     - rdy=0 during MISS: mem_valid=0, state holds; rdy=1 resumes the same miss.
//     - rst_n=0 mid-MISS: mem_valid=0 immediately; all lines invalid afterwards.
//     - With ICACHE_PERF_EN: after tests 1-2, hit_cnt=2, miss_cnt=1.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache in front of memCtrl; define ICACHE_PERF_EN for hit/miss counters
module icache_direct #(
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 30 - INDEX_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   output logic [31:0] if_inst,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   input  logic        mem_enable,
   input  logic [31:0] mem_data
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int LINES = 2 ** INDEX_W;
   typedef enum logic {IDLE, MISS} state_t;
   state_t             state, state_nx;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tag_mem [LINES];
   logic [31:0]        data_mem [LINES];
   logic [31:0]        miss_pc;
   logic [INDEX_W-1:0] idx, miss_idx;
   logic [TAG_W-1:0]   pc_tag;
   logic               hit, miss_start, fill, unused_lsb;
   assign idx        = if_pc[INDEX_W+1:2];
   assign pc_tag     = if_pc[31:INDEX_W+2];
   assign miss_idx   = miss_pc[INDEX_W+1:2];
   assign unused_lsb = ^if_pc[1:0];
   assign hit        = valid[idx] && tag_mem[idx] == pc_tag;
   assign if_inst    = data_mem[idx];
   assign mem_addr   = miss_pc;
   // Lookup, miss request and next-state; everything is gated by rdy so a frozen pipeline stays put
   always_comb begin
      if_ready   = rdy && state == IDLE && if_valid && hit && !flush;
      miss_start = rdy && state == IDLE && if_valid && !hit && !flush;
      mem_valid  = rdy && state == MISS && !mem_enable && !flush;
      fill       = rdy && state == MISS && mem_enable;
      state_nx   = miss_start ? MISS : (rdy && state == MISS && (mem_enable || flush)) ? IDLE : state;
   end
   // Control state: a fill still lands when flush coincides with mem_enable since the data matches miss_pc
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         valid   <= '0;
         miss_pc <= '0;
      end else begin
         state <= state_nx;
         if (miss_start) miss_pc <= {if_pc[31:2], 2'b00};
         if (fill) valid[miss_idx] <= 1'b1;
      end
   end
   // Line storage is not reset; valid[] alone qualifies it
   always_ff @(posedge clk) begin
      if (fill) begin
         data_mem[miss_idx] <= mem_data;
         tag_mem[miss_idx]  <= miss_pc[31:INDEX_W+2];
      end
   end
`ifdef ICACHE_PERF_EN
   // Hit/miss counters, wrapping, frozen with rdy through the gated strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (if_ready) hit_cnt <= hit_cnt + 32'd1;
         if (miss_start) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: table-driven directed vectors for icache_direct plus hand sequences for reset mid-miss
module tb_icache_direct;
   logic        clk = 1'b0;
   logic        rst_n, rdy, flush, if_valid, mem_enable;
   logic [31:0] if_pc, mem_data;
   logic        if_ready, mem_valid;
   logic [31:0] if_inst, mem_addr;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif
   int          n_vec = 0;
   int          errs  = 0;
   typedef struct {
      string       name;
      logic        rdy, flush, v;
      logic [31:0] pc;
      logic        en;
      logic [31:0] data;
      logic        e_ready, e_mv;
      logic [31:0] e_addr, e_inst;
   } vec_t;
   vec_t vq[$];
   icache_direct dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
      .if_ready(if_ready), .if_inst(if_inst), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_enable(mem_enable), .mem_data(mem_data)
`ifdef ICACHE_PERF_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(string n, logic r, logic f, logic v, logic [31:0] pc, logic en, logic [31:0] d,
                               logic er, logic emv, logic [31:0] ea, logic [31:0] ei);
      vec_t t;
      t.name = n; t.rdy = r; t.flush = f; t.v = v; t.pc = pc; t.en = en; t.data = d;
      t.e_ready = er; t.e_mv = emv; t.e_addr = ea; t.e_inst = ei;
      return t;
   endfunction
   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask
   task automatic drive(vec_t t);
      rdy = t.rdy; flush = t.flush; if_valid = t.v; if_pc = t.pc; mem_enable = t.en; mem_data = t.data;
   endtask
   task automatic apply(vec_t t);
      drive(t);
      #4;
      n_vec++;
      chk({t.name, ".if_ready"}, {31'd0, if_ready}, {31'd0, t.e_ready});
      chk({t.name, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, t.e_mv});
      if (t.e_mv) chk({t.name, ".mem_addr"}, mem_addr, t.e_addr);
      if (t.e_ready) chk({t.name, ".if_inst"}, if_inst, t.e_inst);
      @(posedge clk);
      #1;
   endtask
   initial begin
      vq.push_back(mk("cold_detect",  1,0,1,32'h1004,0,0,           0,0,0,0));
      vq.push_back(mk("cold_req",     1,0,1,32'h1004,0,0,           0,1,32'h1004,0));
      vq.push_back(mk("cold_fill",    1,0,1,32'h1004,1,32'h00A00093,0,0,0,0));
      vq.push_back(mk("cold_retry",   1,0,1,32'h1004,0,0,           1,0,0,32'h00A00093));
      vq.push_back(mk("hit",          1,0,1,32'h1004,0,0,           1,0,0,32'h00A00093));
      vq.push_back(mk("idle",         1,0,0,32'h1004,0,0,           0,0,0,0));
      vq.push_back(mk("conf_detect",  1,0,1,32'h1404,0,0,           0,0,0,0));
      vq.push_back(mk("conf_req",     1,0,1,32'h1404,0,0,           0,1,32'h1404,0));
      vq.push_back(mk("conf_fill",    1,0,1,32'h1404,1,32'h11111111,0,0,0,0));
      vq.push_back(mk("conf_hit",     1,0,1,32'h1404,0,0,           1,0,0,32'h11111111));
      vq.push_back(mk("evict_detect", 1,0,1,32'h1004,0,0,           0,0,0,0));
      vq.push_back(mk("evict_req",    1,0,1,32'h1004,0,0,           0,1,32'h1004,0));
      vq.push_back(mk("evict_fill",   1,0,1,32'h1004,1,32'h00A00093,0,0,0,0));
      vq.push_back(mk("evict_hit",    1,0,1,32'h1004,0,0,           1,0,0,32'h00A00093));
      vq.push_back(mk("fl_detect",    1,0,1,32'h2000,0,0,           0,0,0,0));
      vq.push_back(mk("fl_req1",      1,0,1,32'h2000,0,0,           0,1,32'h2000,0));
      vq.push_back(mk("fl_req2",      1,0,1,32'h2000,0,0,           0,1,32'h2000,0));
      vq.push_back(mk("fl_abort",     1,1,1,32'h2000,0,0,           0,0,0,0));
      vq.push_back(mk("fl_idle",      1,0,0,32'h2000,0,0,           0,0,0,0));
      vq.push_back(mk("fl_remiss",    1,0,1,32'h2000,0,0,           0,0,0,0));
      vq.push_back(mk("fl_req3",      1,0,1,32'h2000,0,0,           0,1,32'h2000,0));
      vq.push_back(mk("fl_en_fill",   1,1,1,32'h2000,1,32'h22222222,0,0,0,0));
      vq.push_back(mk("fl_en_hit",    1,0,1,32'h2000,0,0,           1,0,0,32'h22222222));
      vq.push_back(mk("idle_flush",   1,1,1,32'h2000,0,0,           0,0,0,0));
      vq.push_back(mk("after_iflush", 1,0,1,32'h2000,0,0,           1,0,0,32'h22222222));
      vq.push_back(mk("rdy_detect",   1,0,1,32'h3004,0,0,           0,0,0,0));
      vq.push_back(mk("rdy_req",      1,0,1,32'h3004,0,0,           0,1,32'h3004,0));
      vq.push_back(mk("rdy_low",      0,0,1,32'h3004,0,0,           0,0,0,0));
      vq.push_back(mk("rdy_low_en",   0,0,1,32'h3004,1,32'hDEADBEEF,0,0,0,0));
      vq.push_back(mk("rdy_resume",   1,0,1,32'h3004,0,0,           0,1,32'h3004,0));
      vq.push_back(mk("rdy_fill",     1,0,1,32'h3004,1,32'h33333333,0,0,0,0));
      vq.push_back(mk("rdy_hit",      1,0,1,32'h3004,0,0,           1,0,0,32'h33333333));
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; mem_enable = 1'b0; mem_data = '0;
      #12;
      n_vec++;
      chk("rst.if_ready", {31'd0, if_ready}, 32'd0);
      chk("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
      chk("rst.hit_cnt", hit_cnt, 32'd0);
      chk("rst.miss_cnt", miss_cnt, 32'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i]);
`ifdef ICACHE_PERF_EN
         if (i == 4) begin
            chk("perf.hit_cnt", hit_cnt, 32'd2);
            chk("perf.miss_cnt", miss_cnt, 32'd1);
         end
`endif
      end
      apply(mk("rst_detect", 1,0,1,32'h4008,0,0, 0,0,0,0));
      drive(mk("rst_req", 1,0,1,32'h4008,0,0, 0,0,0,0));
      #2;
      n_vec++;
      chk("rst_req.mem_valid", {31'd0, mem_valid}, 32'd1);
      chk("rst_req.mem_addr", mem_addr, 32'h4008);
      rst_n = 1'b0;
      #1;
      n_vec++;
      chk("rst_mid.mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mid.mem_addr", mem_addr, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply(mk("post_rst_3004", 1,0,1,32'h3004,0,0, 0,0,0,0));
      apply(mk("post_rst_flush", 1,1,0,32'h3004,0,0, 0,0,0,0));
      apply(mk("post_rst_2000", 1,0,1,32'h2000,0,0, 0,0,0,0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
      $finish;
   end
endmodule
